// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   ADDR_W      : byte-address / instruction word width (32)
//   ST_*        : 2-bit state encodings for the fetch FSM
//   state_t     : enumerated FSM state type built on the ST_* encodings
//   EBREAK_INSN : instruction encoding that halts fetch (default for the
//                 top-level EBREAK_WORD parameter)
package fetch_pkg;

  localparam int ADDR_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_HALT  = ST_HALT,
    S_FAULT = ST_FAULT
  } state_t;

  localparam logic [ADDR_W-1:0] EBREAK_INSN = 32'h0010_0073;

endpackage

// File: rtl/fetch_out_stage.sv
// Valid/ready output register holding one fetched instruction and its PC.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_instr/load_pc and mark valid
//   flush      : drop any held instruction (highest priority)
//   accept     : consumer took the held instruction this cycle
//   load_instr : word to capture
//   load_pc    : byte address the word was fetched from
//   valid      : instr/instr_pc hold a fetched instruction
//   instr      : held instruction word
//   instr_pc   : held instruction address
module fetch_out_stage
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic              accept,
  input  logic [ADDR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0] load_pc,
  output logic              valid,
  output logic [ADDR_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc
);

  logic              vld_p1;
  logic [ADDR_W-1:0] instr_p1;
  logic [ADDR_W-1:0] pc_p1;

  // Fetch -> decode boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
    end else begin
      // A new load wins over an accept: the accepted word is replaced in
      // the same cycle, so the stage stays full.
      if (flush)       vld_p1 <= 1'b0;
      else if (load)   vld_p1 <= 1'b1;
      else if (accept) vld_p1 <= 1'b0;

      if (load && !flush) begin
        instr_p1 <= load_instr;
        pc_p1    <= load_pc;
      end
    end
  end

  assign valid    = vld_p1;
  assign instr    = instr_p1;
  assign instr_pc = pc_p1;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a combinational instruction memory. Owns the fetch PC,
// registers each fetched word into a valid/ready output stage, follows
// branch/jump redirects and stops on EBREAK or an illegal fetch address.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : pulse; (re)starts fetch at RESET_PC unless already running
//   imem_addr       : byte address to instruction memory (= fetch PC)
//   imem_rd         : instruction memory read data, same cycle as imem_addr
//   redirect_valid  : taken branch/jump this cycle
//   redirect_pc     : redirect target byte address
//   instr_valid     : instr/instr_pc hold a fetched instruction
//   instr_ready     : consumer accepts the instruction this cycle
//   instr, instr_pc : fetched word and its byte address
//   halted, fault   : FSM is in HALT / FAULT
//   fault_pc        : offending address latched on entry to FAULT
//   fetch_count     : words loaded into the output stage since last start
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          IMEM_WORDS  = 256,
  parameter logic [31:0] EBREAK_WORD = EBREAK_INSN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [ADDR_W-1:0] imem_rd,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc,
  output logic [ADDR_W-1:0] fetch_count
);

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(IMEM_WORDS * 4);

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic              load_en;
  logic              do_load;
  logic              do_flush;
  logic              do_accept;

  // Word-aligned and inside the memory; unsigned compare.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && (a < ADDR_LIMIT);
  endfunction

  always_comb begin
    load_en   = (state == S_RUN) && !redirect_valid && (!instr_valid || instr_ready);
    do_load   = load_en && in_range(fetch_pc);
    // Restart discards any pending word; a redirect in RUN flushes the
    // wrong-path word even if the consumer is taking it this cycle.
    do_flush  = (start && (state != S_RUN)) || ((state == S_RUN) && redirect_valid);
    do_accept = instr_ready && (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (redirect_valid) begin
            if (in_range(redirect_pc)) begin
              fetch_pc <= redirect_pc;
            end else begin
              state    <= S_FAULT;
              fault_pc <= redirect_pc;
            end
          end else if (load_en) begin
            if (in_range(fetch_pc)) begin
              fetch_pc    <= fetch_pc + 32'd4;
              fetch_count <= fetch_count + 32'd1;
              // EBREAK itself is still delivered downstream.
              if (imem_rd == EBREAK_WORD) state <= S_HALT;
            end else begin
              state    <= S_FAULT;
              fault_pc <= fetch_pc;
            end
          end
        end
        default: begin
          // IDLE, HALT and FAULT all restart identically; fault_pc is kept.
          if (start) begin
            state       <= S_RUN;
            fetch_pc    <= RESET_PC;
            fetch_count <= '0;
          end
        end
      endcase
    end
  end

  fetch_out_stage u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (do_load),
    .flush      (do_flush),
    .accept     (do_accept),
    .load_instr (imem_rd),
    .load_pc    (fetch_pc),
    .valid      (instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

  assign imem_addr = fetch_pc;
  assign halted    = (state == S_HALT);
  assign fault     = (state == S_FAULT);

endmodule
